// File: rtl/instruction_register.sv
// rtl/instruction_register.sv - 16-bit instruction register with sign-extended immediate and optional scan (IR_SCAN_EN)
module instruction_register (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] SysBus,
  input  logic        IrWe,
  input  logic        ImmSel,
  input  logic        Test,
  input  logic        SDI,
  output logic [15:0] Ir,
  output logic [15:0] Imm
);

  logic [15:0] Ir_q;

`ifdef IR_SCAN_EN
  // Scan shift has priority over a bus load; Ir_q[15] feeds the next chain element
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Ir_q <= 16'h0000;
    end else if (Test) begin
      Ir_q <= {Ir_q[14:0], SDI};
    end else if (IrWe) begin
      Ir_q <= SysBus;
    end
  end
`else
  // Scan path not built: Test and SDI are kept as ports only
  logic unused_scan;
  assign unused_scan = ^{Test, SDI};

  // Capture the instruction word from the bus when the control unit asks for it
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Ir_q <= 16'h0000;
    end else if (IrWe) begin
      Ir_q <= SysBus;
    end
  end
`endif

  assign Ir = Ir_q;

  // Immediate is always sign-extended: short form from bits 4:0, long form from bits 7:0
  always_comb begin
    Imm = 16'h0000;
    if (ImmSel) begin
      Imm = {{11{Ir_q[4]}}, Ir_q[4:0]};
    end else begin
      Imm = {{8{Ir_q[7]}}, Ir_q[7:0]};
    end
  end

endmodule

// File: tb/tb_instruction_register.sv
// tb/tb_instruction_register.sv - self-checking bench for instruction_register
module tb_instruction_register;

  logic        Clock;
  logic        nReset;
  logic [15:0] SysBus;
  logic        IrWe;
  logic        ImmSel;
  logic        Test;
  logic        SDI;
  logic [15:0] Ir;
  logic [15:0] Imm;

  int errors = 0;
  int checks = 0;
  int model_ir = 0;

`ifdef IR_SCAN_EN
  localparam bit scan_built = 1'b1;
`else
  localparam bit scan_built = 1'b0;
`endif

  instruction_register dut (
    .Clock  (Clock),
    .nReset (nReset),
    .SysBus (SysBus),
    .IrWe   (IrWe),
    .ImmSel (ImmSel),
    .Test   (Test),
    .SDI    (SDI),
    .Ir     (Ir),
    .Imm    (Imm)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Immediate as a signed number, then wrapped to 16 bits
  function automatic logic [15:0] ref_imm(input int ir, input logic sel);
    int v;
    if (sel) begin
      v = ir % 32;
      if (v >= 16) v = v - 32;
    end else begin
      v = ir % 256;
      if (v >= 128) v = v - 256;
    end
    v = v & 32'hFFFF;
    return v[15:0];
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge: advance the model with the inputs present at the edge
  task automatic cycle();
    @(posedge Clock);
    if (nReset) begin
      if (scan_built && Test) model_ir = ((model_ir * 2) + int'(SDI)) % 65536;
      else if (IrWe)          model_ir = int'(SysBus);
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] e;
    e = model_ir[15:0];
    check({tag, "_ir"}, Ir, e);
    check({tag, "_imm"}, Imm, ref_imm(model_ir, ImmSel));
  endtask

  initial begin
    logic [15:0] bus_word;
    logic [15:0] exp_scan;
    logic [3:0]  sdi_seq;

    nReset = 1'b0; SysBus = 16'h1234; IrWe = 1'b1; ImmSel = 1'b0; Test = 1'b0; SDI = 1'b0;
    #2;
    check("reset_ir", Ir, 16'h0000);
    check("reset_imm", Imm, 16'h0000);
    cycle();
    check("reset_held_ir", Ir, 16'h0000);
    check("reset_held_imm", Imm, 16'h0000);
    model_ir = 0;

    // Reset then no write
    @(negedge Clock);
    nReset = 1'b1; SysBus = 16'hFFFF; IrWe = 1'b0;
    cycle();
    check("no_write", Ir, 16'h0000);

    // Load, then bus changes with write disabled
    IrWe = 1'b1; SysBus = 16'hFFFF;
    cycle();
    check("load_ffff", Ir, 16'hFFFF);
    IrWe = 1'b0; SysBus = 16'h001F;
    cycle();
    check("hold_ffff", Ir, 16'hFFFF);

    // Short and long immediates
    IrWe = 1'b1; SysBus = 16'h001F; ImmSel = 1'b1;
    cycle();
    check("short_001f", Imm, 16'hFFFF);
    ImmSel = 1'b0; #1;
    check("long_001f", Imm, 16'h001F);
    SysBus = 16'h00EF; ImmSel = 1'b1;
    cycle();
    check("short_00ef", Imm, 16'h000F);
    ImmSel = 1'b0; #1;
    check("long_00ef", Imm, 16'hFFEF);

    // Same word loaded on consecutive edges stays stable
    cycle();
    check("reload_same", Ir, 16'h00EF);

    // Scan shift vs bus load, starting from a cleared register
    @(negedge Clock);
    nReset = 1'b0; #1; nReset = 1'b1; model_ir = 0;
    check("scan_start", Ir, 16'h0000);
    bus_word = 16'hA5C3;
    sdi_seq = 4'b1011;
    Test = 1'b1; IrWe = 1'b1; SysBus = bus_word;
    for (int i = 3; i >= 0; i--) begin
      SDI = sdi_seq[i];
      cycle();
    end
    exp_scan = scan_built ? 16'h000B : bus_word;
    check("scan_result", Ir, exp_scan);
    Test = 1'b0; SDI = 1'b0;

    // Async reset between edges
    IrWe = 1'b1; SysBus = 16'hFFFF;
    cycle();
    check("pre_async", Ir, 16'hFFFF);
    @(negedge Clock);
    #2;
    nReset = 1'b0; model_ir = 0;
    #1;
    check("async_ir", Ir, 16'h0000);
    check("async_imm", Imm, 16'h0000);
    ImmSel = 1'b1; #1;
    check("async_imm_short", Imm, 16'h0000);
    @(negedge Clock);
    nReset = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      SysBus = 16'($urandom);
      IrWe   = 1'($urandom_range(0, 1));
      Test   = ($urandom_range(0, 3) == 0);
      SDI    = 1'($urandom_range(0, 1));
      ImmSel = 1'($urandom_range(0, 1));
      cycle();
      check_all("rand");
      ImmSel = ~ImmSel; #1;
      check("rand_imm_flip", Imm, ref_imm(model_ir, ImmSel));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
